// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared states, frame constants and timing helper for the DAC scheduler
package dac_sched_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_LO   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam int FRAME_BITS = 24;
  localparam logic [7:0] SMP_CTRL = 8'h00;
  function automatic int frame_cyc(input int sclk_div, input int sync_gap);
    return 1 + 2 * FRAME_BITS * sclk_div + sync_gap;
  endfunction
endpackage

// File: rtl/dac_spi_shifter.sv
// dac_spi_shifter: serialises one 24-bit word MSB first on SYNC/SCLK/DIN
module dac_spi_shifter
  import dac_sched_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int SYNC_GAP = 4
) (
  input  logic                  CLK_100,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  busy,
  output logic                  sync,
  output logic                  sclk,
  output logic                  din
);
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] word_q, word_d;
  logic sync_q, sync_d, sclk_q, sclk_d, din_q, din_d;
  logic div_end, gap_end;
  assign div_end = cnt_q == 8'(SCLK_DIV - 1);
  // the IDLE cycle that precedes the next LOAD completes the SYNC-high gap
  assign gap_end = cnt_q == 8'(SYNC_GAP - 2);
  assign busy = state_q != ST_IDLE;
  assign sync = sync_q;
  assign sclk = sclk_q;
  assign din  = din_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    word_d  = word_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        word_d  = word;
        sync_d  = 1'b0;
        din_d   = word[FRAME_BITS-1];
        bit_d   = 5'(FRAME_BITS - 1);
      end
      ST_LOAD: begin
        state_d = ST_HI;
        cnt_d   = '0;
      end
      ST_HI: if (div_end) begin
        state_d = ST_LO;
        sclk_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_LO: if (div_end) begin
        cnt_d  = '0;
        sclk_d = 1'b1;
        if (bit_q != 5'd0) begin
          state_d = ST_HI;
          bit_d   = bit_q - 5'd1;
          din_d   = word_q[bit_q-5'd1];
        end else begin
          state_d = ST_GAP;
          sync_d  = 1'b1;
          din_d   = 1'b0;
        end
      end
      ST_GAP: if (gap_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
    end
  end
endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler: sample tick, sample hold and sample/command arbitration for the DAC link
module dac_frame_scheduler
  import dac_sched_pkg::*;
#(
  parameter int RATE_DIV = 2083,
  parameter int SCLK_DIV = 2,
  parameter int SYNC_GAP = 4
) (
  input  logic        CLK_100,
  input  logic        RESET_N,
  input  logic        SMP_VALID,
  input  logic [15:0] SMP_DATA,
  output logic        SMP_READY,
  input  logic        CMD_VALID,
  input  logic [23:0] CMD_DATA,
  output logic        CMD_READY,
  output logic        SYNC,
  output logic        SCLK,
  output logic        DIN,
  output logic        BUSY,
  output logic        TICK,
  output logic        UNDERRUN
);
  localparam int CW = $clog2(RATE_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_full_q, hold_full_d, pending_q, pending_d;
  logic [15:0] hold_q, hold_d, last_q, last_d;
  logic busy, idle, fresh, take, accept, sample_req, start;
  logic [FRAME_BITS-1:0] word;
  // a tick on an idle link starts its sample frame in the same cycle, so it also beats a waiting command
  assign TICK       = cnt_q == CW'(RATE_DIV - 1);
  assign fresh      = TICK & !pending_q;
  assign take       = fresh & hold_full_q;
  assign UNDERRUN   = fresh & !hold_full_q;
  assign accept     = SMP_VALID & !hold_full_q;
  assign idle       = !busy;
  assign sample_req = pending_q | fresh;
  assign start      = idle & (sample_req | CMD_VALID);
  assign CMD_READY  = idle & !sample_req & CMD_VALID;
  assign word       = sample_req ? {SMP_CTRL, take ? hold_q : last_q} : CMD_DATA;
  assign SMP_READY  = !hold_full_q;
  assign BUSY       = busy;
  always_comb begin
    cnt_d       = TICK ? '0 : cnt_q + CW'(1);
    hold_full_d = accept | (hold_full_q & !take);
    hold_d      = accept ? SMP_DATA : hold_q;
    last_d      = take ? hold_q : last_q;
    pending_d   = !idle & sample_req;
  end
  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      last_q      <= '0;
      pending_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
    end
  end
  dac_spi_shifter #(.SCLK_DIV(SCLK_DIV), .SYNC_GAP(SYNC_GAP)) u_shifter (
    .CLK_100 (CLK_100),
    .RESET_N (RESET_N),
    .start   (start),
    .word    (word),
    .busy    (busy),
    .sync    (SYNC),
    .sclk    (SCLK),
    .din     (DIN)
  );
endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler: directed checks of tick, hold, arbitration and frame timing
module tb_dac_frame_scheduler;
  localparam int RD = 300, SD = 2, SG = 4;
  logic clk = 1'b0, rst_n = 1'b0, smp_valid = 1'b0, cmd_valid = 1'b0;
  logic [15:0] smp_data = '0;
  logic [23:0] cmd_data = '0;
  logic SMP_READY, CMD_READY, SYNC, SCLK, DIN, BUSY, TICK, UNDERRUN;
  int n_chk = 0, n_fail = 0;
  int n_under = 0, n_rdy = 0, n_rdy_busy = 0, n_din_bad = 0, n_fall = 0;
  int edges = 0, low_len = 0, high_len = 0, first = 0, cur_gap = 0, n = 0;
  logic sync_p = 1'b1, sclk_p = 1'b1, din_p = 1'b0;
  logic [23:0] sh = '0;
  logic [23:0] frm_word[$];
  int frm_edges[$], frm_low[$], frm_first[$], frm_gap[$];

  dac_frame_scheduler #(.RATE_DIV(RD), .SCLK_DIV(SD), .SYNC_GAP(SG)) dut (
    .CLK_100(clk), .RESET_N(rst_n), .SMP_VALID(smp_valid), .SMP_DATA(smp_data),
    .SMP_READY(SMP_READY), .CMD_VALID(cmd_valid), .CMD_DATA(cmd_data), .CMD_READY(CMD_READY),
    .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN), .BUSY(BUSY), .TICK(TICK), .UNDERRUN(UNDERRUN)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame monitor: decodes DIN on each SCLK fall while SYNC is low
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sync_p = 1'b1; sclk_p = 1'b1; din_p = 1'b0; high_len = 0;
    end else begin
      if (UNDERRUN) n_under++;
      if (CMD_READY) n_rdy++;
      if (CMD_READY && BUSY) n_rdy_busy++;
      if (!SCLK && DIN !== din_p) n_din_bad++;
      if (sync_p && !SYNC) begin
        n_fall++; cur_gap = high_len; sh = '0; edges = 0; low_len = 0; first = 0;
      end
      if (!SYNC) begin
        low_len++;
        if (sclk_p && !SCLK) begin
          sh = {sh[22:0], DIN};
          edges++;
          if (edges == 1) first = low_len - 1;
        end
      end
      if (!sync_p && SYNC) begin
        frm_word.push_back(sh); frm_edges.push_back(edges); frm_low.push_back(low_len);
        frm_first.push_back(first); frm_gap.push_back(cur_gap);
        high_len = 0;
      end
      if (SYNC) high_len++;
      sync_p = SYNC; sclk_p = SCLK; din_p = DIN;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int cnt);
    int k = 0;
    while (frm_word.size() < cnt && k < 4 * RD) begin step(); k++; end
    check($sformatf("frames_%0d", cnt), frm_word.size(), cnt);
  endtask

  task automatic wait_tick();
    n = 0;
    do begin step(); n++; end while (!TICK && n < 2 * RD);
  endtask

  task automatic wait_sync_low();
    int k = 0;
    while (SYNC && k < 2 * RD) begin step(); k++; end
    check("sync_fall", SYNC, 0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!CMD_READY && k < 2 * RD) begin step(); k++; end
    check("cmd_ready_wait", CMD_READY, 1);
  endtask

  task automatic chk_frame(input int i, input logic [23:0] w);
    if (i < frm_word.size()) begin
      check($sformatf("f%0d_word", i), frm_word[i], w);
      check($sformatf("f%0d_edges", i), frm_edges[i], 24);
      check($sformatf("f%0d_sync_low", i), frm_low[i], 1 + 48 * SD);
      check($sformatf("f%0d_first_fall", i), frm_first[i], 1 + SD);
    end else check($sformatf("f%0d_missing", i), frm_word.size(), i + 1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_sync", SYNC, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_din", DIN, 0);
    check("rst_busy", BUSY, 0);
    check("rst_tick", TICK, 0);
    check("rst_underrun", UNDERRUN, 0);
    check("rst_smp_ready", SMP_READY, 1);
    check("rst_cmd_ready", CMD_READY, 0);
    #1 rst_n = 1'b1;
    // 1: first tick underruns and sends zero
    wait_tick();
    check("tick1_at", n, RD - 1);
    check("tick1_underrun", UNDERRUN, 1);
    wait_frames(1);
    chk_frame(0, 24'h000000);
    check("underrun_cnt1", n_under, 1);
    // 2: fresh sample
    step();
    smp_data = 16'hA5C3; smp_valid = 1'b1;
    @(posedge clk); #1 smp_valid = 1'b0;
    check("smp_ready_full", SMP_READY, 0);
    wait_frames(2);
    chk_frame(1, 24'h00A5C3);
    check("smp_ready_after_tick", SMP_READY, 1);
    check("underrun_cnt2", n_under, 1);
    // 3: no new sample, last one resent
    wait_frames(3);
    chk_frame(2, 24'h00A5C3);
    check("underrun_cnt3", n_under, 2);
    // 4: command raised during a sample frame
    wait_sync_low();
    cmd_data = 24'h030000; cmd_valid = 1'b1;
    check("cmd_ready_busy", CMD_READY, 0);
    wait_ready();
    check("cmd_after_frame", frm_word.size(), 4);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_frames(5);
    chk_frame(3, 24'h00A5C3);
    chk_frame(4, 24'h030000);
    if (frm_gap.size() > 4) check("gap_cmd4", frm_gap[4], SG);
    check("cmd_ready_cnt4", n_rdy, 1);
    // 5: tick and command in the same idle cycle
    wait_tick();
    check("tick5", TICK, 1);
    cmd_data = 24'h5A5A5A; cmd_valid = 1'b1;
    check("cmd_ready_on_tick", CMD_READY, 0);
    step();
    check("tick_to_sync", SYNC, 0);
    wait_ready();
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_frames(7);
    chk_frame(5, 24'h00A5C3);
    chk_frame(6, 24'h5A5A5A);
    if (frm_gap.size() > 6) check("gap_cmd6", frm_gap[6], SG);
    check("cmd_ready_cnt5", n_rdy, 2);
    check("underrun_cnt5", n_under, 4);
    // 6: reset after the 10th falling edge with a sample held
    wait_sync_low();
    smp_data = 16'h1234; smp_valid = 1'b1;
    @(posedge clk); #1 smp_valid = 1'b0;
    check("hold_full_pre_rst", SMP_READY, 0);
    n = 0;
    while (edges < 10 && n < RD) begin step(); n++; end
    check("edges_before_rst", edges, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_sync", SYNC, 1);
    check("midrst_sclk", SCLK, 1);
    check("midrst_din", DIN, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_smp_ready", SMP_READY, 1);
    repeat (2) step();
    rst_n = 1'b1;
    wait_tick();
    check("tick_after_rst", n, RD - 1);
    check("no_frame_before_tick", n_fall, 8);
    check("rst_underrun", UNDERRUN, 1);
    wait_frames(8);
    chk_frame(7, 24'h000000);
    check("din_stable_sclk_low", n_din_bad, 0);
    check("cmd_ready_never_busy", n_rdy_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
